// File: rtl/conv_hfilter_if.sv
// Video beat bus for conv_hfilter: input beat fields plus the delayed output beat.
interface conv_hfilter_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 3,
  parameter int X_BITS   = 11
);
  logic                      valid;
  logic                      packet_video;
  logic [1:0]                mode;
  logic [X_BITS-1:0]         x_in;
  logic [CHANNELS*WIDTH-1:0] data_in;
  logic                      valid_out;
  logic                      packet_video_out;
  logic [CHANNELS*WIDTH-1:0] data_out;

  // Source side: presents beats, observes filtered beats.
  modport master (
    output valid, packet_video, mode, x_in, data_in,
    input  valid_out, packet_video_out, data_out
  );

  // Filter side.
  modport slave (
    input  valid, packet_video, mode, x_in, data_in,
    output valid_out, packet_video_out, data_out
  );
endinterface

// File: rtl/conv_hfilter.sv
// Horizontal sliding-window filter (bypass / box average / max / min) per channel,
// with left-edge replication and a fixed two-stage pipeline.
module conv_hfilter #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 3,
  parameter int TAPS     = 3,
  parameter int X_BITS   = 11
) (
  input logic           clk,
  input logic           rst,
  conv_hfilter_if.slave bus
);
  localparam int SW = WIDTH + 3;
  localparam logic [SW-1:0] TAPS_DIV = SW'(TAPS);

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_BOX    = 2'd1,
    MODE_MAX    = 2'd2,
    MODE_MIN    = 2'd3
  } mode_t;

  logic [WIDTH-1:0]          hist [CHANNELS][TAPS-1];
  logic [SW-1:0]             s1_next [CHANNELS];
  logic [SW-1:0]             s1_val [CHANNELS];
  mode_t                     s1_mode_next;
  mode_t                     s1_mode;
  logic                      s1_valid;
  logic                      s1_pv;
  logic [CHANNELS*WIDTH-1:0] out_next;
  logic                      row_start;
  logic [WIDTH-1:0]          din_c;
  logic [WIDTH-1:0]          tap;
  logic [WIDTH-1:0]          mx;
  logic [WIDTH-1:0]          mn;
  logic [SW-1:0]             sum;
  logic [SW-1:0]             quot;

  assign row_start = (bus.x_in == '0);

  // Stage-1 window reduction; control beats are forced to bypass so they pass unchanged.
  always_comb begin
    s1_mode_next = bus.packet_video ? mode_t'(bus.mode) : MODE_BYPASS;
    din_c = '0;
    tap   = '0;
    mx    = '0;
    mn    = '0;
    sum   = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      din_c = bus.data_in[c*WIDTH +: WIDTH];
      sum   = SW'(din_c);
      mx    = din_c;
      mn    = din_c;
      for (int unsigned k = 0; k < TAPS - 1; k++) begin
        tap = row_start ? din_c : hist[c][k];
        sum = sum + SW'(tap);
        if (tap > mx) mx = tap;
        if (tap < mn) mn = tap;
      end
      case (s1_mode_next)
        MODE_BYPASS: s1_next[c] = SW'(din_c);
        MODE_BOX:    s1_next[c] = sum;
        MODE_MAX:    s1_next[c] = SW'(mx);
        MODE_MIN:    s1_next[c] = SW'(mn);
      endcase
    end
  end

  // Stage-2 divide (box) or select (all other modes).
  always_comb begin
    out_next = '0;
    quot     = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      quot = s1_val[c] / TAPS_DIV;
      out_next[c*WIDTH +: WIDTH] = (s1_mode == MODE_BOX) ? quot[WIDTH-1:0]
                                                         : s1_val[c][WIDTH-1:0];
    end
  end

  // Row history: shifts on video beats, reloads with the current pixel at x == 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned c = 0; c < CHANNELS; c++)
        for (int unsigned k = 0; k < TAPS - 1; k++)
          hist[c][k] <= '0;
    end else if (bus.valid && bus.packet_video) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        hist[c][0] <= bus.data_in[c*WIDTH +: WIDTH];
        for (int unsigned k = 1; k < TAPS - 1; k++)
          hist[c][k] <= row_start ? bus.data_in[c*WIDTH +: WIDTH] : hist[c][k-1];
      end
    end
  end

  // Stage-1 registers: reduced window plus beat tags; advances every cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_pv    <= 1'b0;
      s1_mode  <= MODE_BYPASS;
      for (int unsigned c = 0; c < CHANNELS; c++) s1_val[c] <= '0;
    end else begin
      s1_valid <= bus.valid;
      s1_pv    <= bus.packet_video;
      s1_mode  <= s1_mode_next;
      for (int unsigned c = 0; c < CHANNELS; c++) s1_val[c] <= s1_next[c];
    end
  end

  // Output registers: data and packet tag hold their last value across bubbles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.valid_out        <= 1'b0;
      bus.packet_video_out <= 1'b0;
      bus.data_out         <= '0;
    end else begin
      bus.valid_out <= s1_valid;
      if (s1_valid) begin
        bus.packet_video_out <= s1_pv;
        bus.data_out         <= out_next;
      end
    end
  end
endmodule

// File: tb/tb_conv_hfilter.sv
// Directed bench for conv_hfilter: TAPS=3 and TAPS=4 instances share one stimulus stream.
module tb_conv_hfilter;
  logic        clk = 1'b0;
  logic        rst;
  logic        v;
  logic        pv;
  logic [1:0]  md;
  logic [10:0] x;
  logic [23:0] din;
  int          n_cmp = 0;
  int          n_err = 0;

  conv_hfilter_if #(.WIDTH(8), .CHANNELS(3), .X_BITS(11)) if3 ();
  conv_hfilter_if #(.WIDTH(8), .CHANNELS(3), .X_BITS(11)) if4 ();

  assign if3.valid = v;  assign if3.packet_video = pv;  assign if3.mode = md;
  assign if3.x_in  = x;  assign if3.data_in      = din;
  assign if4.valid = v;  assign if4.packet_video = pv;  assign if4.mode = md;
  assign if4.x_in  = x;  assign if4.data_in      = din;

  conv_hfilter #(.WIDTH(8), .CHANNELS(3), .TAPS(3), .X_BITS(11)) dut3 (
    .clk(clk), .rst(rst), .bus(if3.slave));
  conv_hfilter #(.WIDTH(8), .CHANNELS(3), .TAPS(4), .X_BITS(11)) dut4 (
    .clk(clk), .rst(rst), .bus(if4.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat, then step one clock and settle away from the edge.
  task automatic beat(input logic vv, input logic pp, input logic [1:0] m,
                      input logic [10:0] xx, input logic [23:0] d);
    v = vv; pv = pp; md = m; x = xx; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    beat(1'b0, 1'b1, 2'd0, 11'd0, 24'h0);
  endtask

  function automatic logic [23:0] px(input logic [7:0] val);
    return {val, val, val};
  endfunction

  // Outputs visible after a beat() call belong to the beat of the previous call.
  initial begin
    rst = 1'b0;
    // Reset held with valid beats presented: nothing comes out.
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, 1'b1, 2'd0, 11'd0, 24'h555555);
      chk("rst_vout", 32'(if3.valid_out), 32'd0);
      chk("rst_dout", 32'(if3.data_out), 32'd0);
    end
    chk("rst_pvout", 32'(if3.packet_video_out), 32'd0);
    rst = 1'b1;
    beat(1'b1, 1'b1, 2'd0, 11'd0, px(8'd77));
    chk("rel_vout_n1", 32'(if3.valid_out), 32'd0);
    idle();
    chk("rel_vout_n2", 32'(if3.valid_out), 32'd1);
    chk("rel_dout", 32'(if3.data_out), 32'(px(8'd77)));
    chk("rel_pvout", 32'(if3.packet_video_out), 32'd1);

    // Box average, TAPS=3.
    beat(1'b1, 1'b1, 2'd1, 11'd0, px(8'd30));
    beat(1'b1, 1'b1, 2'd1, 11'd1, px(8'd60));   chk("box_x0", 32'(if3.data_out), 32'(px(8'd30)));
    beat(1'b1, 1'b1, 2'd1, 11'd2, px(8'd90));   chk("box_x1", 32'(if3.data_out), 32'(px(8'd40)));
    beat(1'b1, 1'b1, 2'd1, 11'd3, px(8'd255));  chk("box_x2", 32'(if3.data_out), 32'(px(8'd60)));
    beat(1'b1, 1'b1, 2'd1, 11'd4, px(8'd0));    chk("box_x3", 32'(if3.data_out), 32'(px(8'd135)));
    idle();                                     chk("box_x4", 32'(if3.data_out), 32'(px(8'd115)));
    idle();                                     chk("box_bubble", 32'(if3.valid_out), 32'd0);

    // Max then min, TAPS=4, back to back.
    beat(1'b1, 1'b1, 2'd2, 11'd0, px(8'd10));
    beat(1'b1, 1'b1, 2'd2, 11'd1, px(8'd200));  chk("max_x0", 32'(if4.data_out), 32'(px(8'd10)));
    beat(1'b1, 1'b1, 2'd2, 11'd2, px(8'd50));   chk("max_x1", 32'(if4.data_out), 32'(px(8'd200)));
    beat(1'b1, 1'b1, 2'd2, 11'd3, px(8'd7));    chk("max_x2", 32'(if4.data_out), 32'(px(8'd200)));
    beat(1'b1, 1'b1, 2'd2, 11'd4, px(8'd9));    chk("max_x3", 32'(if4.data_out), 32'(px(8'd200)));
    beat(1'b1, 1'b1, 2'd3, 11'd0, px(8'd10));   chk("max_x4", 32'(if4.data_out), 32'(px(8'd200)));
    beat(1'b1, 1'b1, 2'd3, 11'd1, px(8'd200));  chk("min_x0", 32'(if4.data_out), 32'(px(8'd10)));
    beat(1'b1, 1'b1, 2'd3, 11'd2, px(8'd50));   chk("min_x1", 32'(if4.data_out), 32'(px(8'd10)));
    beat(1'b1, 1'b1, 2'd3, 11'd3, px(8'd7));    chk("min_x2", 32'(if4.data_out), 32'(px(8'd10)));
    beat(1'b1, 1'b1, 2'd3, 11'd4, px(8'd9));    chk("min_x3", 32'(if4.data_out), 32'(px(8'd7)));
    idle();                                     chk("min_x4", 32'(if4.data_out), 32'(px(8'd7)));
    chk("min_vout", 32'(if4.valid_out), 32'd1);

    // Control beat between video beats; its x_in=0 and mode must be ignored.
    beat(1'b1, 1'b1, 2'd1, 11'd0, px(8'd12));
    beat(1'b1, 1'b0, 2'd2, 11'd0, 24'hABCDEF);
    chk("ctl_v0", 32'(if3.data_out), 32'(px(8'd12)));
    chk("ctl_v0_pv", 32'(if3.packet_video_out), 32'd1);
    beat(1'b1, 1'b1, 2'd1, 11'd1, px(8'd24));
    chk("ctl_word", 32'(if3.data_out), 32'h00ABCDEF);
    chk("ctl_word_pv", 32'(if3.packet_video_out), 32'd0);
    idle();
    chk("ctl_v1", 32'(if3.data_out), 32'(px(8'd16)));
    chk("ctl_v1_pv", 32'(if3.packet_video_out), 32'd1);

    // Bubble and per-beat mode switch.
    beat(1'b1, 1'b1, 2'd1, 11'd0, px(8'd9));
    idle();                                     chk("bub_n2", 32'(if3.data_out), 32'(px(8'd9)));
    chk("bub_n2_v", 32'(if3.valid_out), 32'd1);
    beat(1'b1, 1'b1, 2'd0, 11'd1, px(8'd0));    chk("bub_n3_v", 32'(if3.valid_out), 32'd0);
    chk("bub_n3_hold", 32'(if3.data_out), 32'(px(8'd9)));
    beat(1'b1, 1'b1, 2'd1, 11'd2, px(8'd3));    chk("bub_n4", 32'(if3.data_out), 32'(px(8'd0)));
    chk("bub_n4_v", 32'(if3.valid_out), 32'd1);
    idle();                                     chk("bub_n5", 32'(if3.data_out), 32'(px(8'd4)));

    // Reset mid-row: history and in-flight beats discarded.
    beat(1'b1, 1'b1, 2'd1, 11'd0, px(8'd255));
    beat(1'b1, 1'b1, 2'd1, 11'd1, px(8'd255));
    beat(1'b1, 1'b1, 2'd1, 11'd2, px(8'd255));
    rst = 1'b0;
    beat(1'b1, 1'b1, 2'd1, 11'd3, px(8'd255));
    chk("mid_rst_v", 32'(if3.valid_out), 32'd0);
    chk("mid_rst_d", 32'(if3.data_out), 32'd0);
    rst = 1'b1;
    beat(1'b1, 1'b1, 2'd1, 11'd5, px(8'd0));
    chk("mid_nostale", 32'(if3.valid_out), 32'd0);
    idle();
    chk("mid_v", 32'(if3.valid_out), 32'd1);
    chk("mid_d", 32'(if3.data_out), 32'd0);
    idle();
    chk("mid_tail", 32'(if3.valid_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/conv_hfilter.md
# conv_hfilter

Parametrised horizontal window filter for the vision pipeline. It sits between the video source and the image-processing stage. It applies a per-channel sliding-window operation over the current row: box average, maximum or minimum, with bypass. Window length, channel count and channel width are parameters. Video and control beats leave in order after a fixed two-cycle latency, with left-edge pixel replication.

## Interface
- `WIDTH`, 8: bits per colour channel.
- `CHANNELS`, 3: channels packed in `data_in`/`data_out`; channel 0 in the LSBs.
- `TAPS`, 3: window length, legal 2..8; window = current pixel plus `TAPS-1` previous pixels of the same row.
- `X_BITS`, 11: width of the x coordinate.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `valid`  in  1  input beat present this cycle.
- `packet_video`  in  1  beat belongs to a video packet (1) or control packet (0).
- `mode`  in  2  per-beat operation: 0 bypass, 1 box average, 2 max, 3 min.
- `x_in`  in  `X_BITS`  column of the current pixel, 0 = first pixel of a row.
- `data_in`  in  `CHANNELS*WIDTH`  pixel or control word.
- `valid_out`  out  1  output beat present.
- `packet_video_out`  out  1  `packet_video` of the beat, delayed.
- `data_out`  out  `CHANNELS*WIDTH`  filtered pixel or passed-through control word.

## Operation
- History: a per-channel shift register of `TAPS-1` entries, `h[0]` newest.
  - Updates only on `valid && packet_video`: `h[k] <= h[k-1]`, `h[0] <= data_in`.
- Left-edge replication on a video beat with `x_in == 0`:
  - The window for that beat uses `data_in` for every tap.
  - All `h[*]` load `data_in`.
  - Pixels 0..`TAPS-2` of a row therefore see the first pixel replicated; no black border.
- Window for a video beat: `{data_in, h[0] .. h[TAPS-2]}` per channel, independently per channel.
- Mode 0: `data_out` = `data_in`.
- Mode 1: `data_out` = floor(sum / `TAPS`).
  - Sum is `WIDTH+3` bits; no overflow possible.
  - Result always ≤ `2^WIDTH-1`; no saturation logic needed.
- Mode 2: `data_out` = unsigned maximum of the window.
- Mode 3: `data_out` = unsigned minimum of the window.
- Control beats (`packet_video == 0`):
  - Pass through unchanged with the same latency as video beats, so beat order is preserved.
  - Do not touch the history.
  - `mode` and `x_in` are ignored.
- `mode` is captured with its beat; changing `mode` between beats affects only later beats. History is updated in every mode, including bypass.
- Cycles with `valid == 0`: no history update. Pipeline stages still advance, so a bubble propagates as `valid_out == 0`.

## Timing
- Pipeline, no backpressure; input accepted every cycle.
  - Stage 1: register window sum (or max/min) per channel, plus mode/valid/packet tags.
  - Stage 2: register divide/select result to the outputs.
- Latency: a beat at cycle N appears on the outputs at cycle N+2 with `valid_out = 1`. Throughput is 1 beat/cycle.
- `data_out` and `packet_video_out` are only meaningful when `valid_out = 1`. They hold their last value otherwise.
- Reset (`rst == 0` at a rising edge), including mid-row or mid-packet:
  - Clears all history, both stage registers and all tags.
  - `valid_out = 0`, `packet_video_out = 0`, `data_out = 0` from the next cycle.
  - In-flight beats are discarded.
  - Beats presented while `rst == 0` are dropped.
  - First output after release: 2 cycles after the first valid beat.
- A row that starts mid-window (no `x_in == 0` after reset): the window uses the zeroed history until it fills. This is legal, defined behaviour.
- Back-to-back `x_in == 0` beats: each reloads the history.

## Test plan
- **Reset:** hold `rst = 0` for 3 cycles with `valid = 1` → `valid_out = 0`, `data_out = 0` throughout. After release, one video beat gives `valid_out = 1` exactly 2 cycles later.
- **Box average, TAPS=3, WIDTH=8, one channel checked:** row x=0..4 with values 30, 60, 90, 255, 0.
  - Outputs: 30, 40, 60, 135, 115.
  - 135 = floor(405/3), 115 = floor(345/3).
- **Max/min, TAPS=4:** row 10, 200, 50, 7, 9 with mode 2 → 10, 200, 200, 200, 200. The same row with mode 3 → 10, 10, 10, 7, 7.
- **Control interleave:** video x=0 (value 12), control word `0xABCDEF`, video x=1 (value 24), mode 1, TAPS=3.
  - Outputs in order: 12, `0xABCDEF` with `packet_video_out = 0`, 16.
  - 16 = floor((24+12+12)/3): the control beat did not shift the history.
- **Bubbles and mode switch:**
  - x=0 (value 9) mode 1, one idle cycle, x=1 (value 0) mode 0, x=2 (value 3) mode 1 → outputs 9, 0, 4 on cycles N+2, N+4, N+5.
  - 4 = floor((3+0+9)/3).
  - `valid_out = 0` at N+3.
- **Reset mid-row:** after 3 pixels of 255, assert reset for 1 cycle, then send x=5 (value 0) with mode 1, TAPS=3 → output 0 (zeroed history). No stale beats appear.
